bsg_manycore_xbar_rr: RTL and testbench

Parametrised single-flit packet crossbar for the manycore crossbar-network testbench family. It connects `num_in_p` source links to `num_out_p` destination links. Each input has a per-input FIFO, and each input is selectable as valid/ready or credit-return mode. Each output has its own round-robin arbiter. The block replaces fixed tile/IO port mapping with a generic N×M switch that reports errors, and is instantiated once per network direction (fwd, rev).

---
 rtl/bsg_manycore_xbar_rr.sv | 158 +++++++++++++++
 tb/tb_bsg_manycore_xbar_rr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_xbar_rr.sv
// Single-flit N x M crossbar: per-input FIFO (valid/ready or credit mode), per-output round-robin arbiter.
// Latency 1 cycle enqueue-to-v_o; backpressure via registered-full ready_o or credit_o pulses on dequeue.
module bsg_manycore_xbar_rr #(
    parameter int                  num_in_p      = 4,
    parameter int                  num_out_p     = 3,
    parameter int                  width_p       = 16,
    parameter int                  dest_lsb_p    = 0,
    parameter int                  fifo_els_p    = 32,
    parameter logic [num_in_p-1:0] use_credits_p = '0
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_in_p-1:0]                 v_i,
    input  logic [num_in_p-1:0][width_p-1:0]    data_i,
    output logic [num_in_p-1:0]                 ready_o,
    output logic [num_in_p-1:0]                 credit_o,
    output logic [num_out_p-1:0]                v_o,
    output logic [num_out_p-1:0][width_p-1:0]   data_o,
    input  logic [num_out_p-1:0]                yumi_i,
    output logic [num_in_p-1:0]                 overflow_o,
    output logic [num_in_p-1:0]                 bad_dest_o
);

    localparam int dest_width_lp = (num_out_p > 1) ? $clog2(num_out_p) : 1;
    localparam int addr_w_lp     = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int cnt_w_lp      = $clog2(fifo_els_p + 1);
    localparam int ptr_w_lp      = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef logic [addr_w_lp-1:0]     addr_t;
    typedef logic [cnt_w_lp-1:0]      cnt_t;
    typedef logic [ptr_w_lp-1:0]      ptr_t;
    typedef logic [dest_width_lp-1:0] dest_t;

    logic [width_p-1:0] mem_q [num_in_p][fifo_els_p];
    addr_t [num_in_p-1:0] rd_q, wr_q;
    cnt_t  [num_in_p-1:0] cnt_q;
    ptr_t  [num_out_p-1:0] ptr_q;
    logic  [num_in_p-1:0] credit_q, overflow_q, bad_dest_q;

    logic  [num_in_p-1:0][width_p-1:0] head;
    dest_t [num_in_p-1:0] head_dest;
    logic  [num_in_p-1:0] nonempty, full, bad_head;
    logic  [num_out_p-1:0][num_in_p-1:0] req;
    logic  [num_out_p-1:0] win_v;
    ptr_t  [num_out_p-1:0] win;
    logic  [num_in_p-1:0] deq, enq, ovf_set;

    function automatic addr_t inc_addr(input addr_t a);
        return (a == addr_t'(fifo_els_p - 1)) ? '0 : a + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < num_in_p; i++) begin
            head[i]      = mem_q[i][rd_q[i]];
            head_dest[i] = head[i][dest_lsb_p +: dest_width_lp];
            nonempty[i]  = (cnt_q[i] != '0);
            full[i]      = (cnt_q[i] == cnt_t'(fifo_els_p));
            // Out-of-range heads are flushed immediately so they never block the input.
            bad_head[i]  = nonempty[i] &&
                           ({1'b0, head_dest[i]} >= (dest_width_lp + 1)'(num_out_p));
        end
    end

    always_comb begin
        for (int o = 0; o < num_out_p; o++) begin
            for (int i = 0; i < num_in_p; i++) begin
                req[o][i] = nonempty[i] && !bad_head[i] && (head_dest[i] == dest_t'(o));
            end
        end
    end

    // Winner is the first requester at or after the pointer, wrapping around.
    always_comb begin
        int idx;
        win_v = '0;
        win   = '0;
        for (int o = 0; o < num_out_p; o++) begin
            for (int k = 0; k < num_in_p; k++) begin
                idx = int'(ptr_q[o]) + k;
                if (idx >= num_in_p) idx = idx - num_in_p;
                if (!win_v[o] && req[o][idx]) begin
                    win_v[o] = 1'b1;
                    win[o]   = ptr_t'(idx);
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < num_out_p; o++) begin
            v_o[o]    = win_v[o] && !reset_i;
            data_o[o] = head[win[o]];
        end
    end

    always_comb begin
        deq = bad_head;
        for (int o = 0; o < num_out_p; o++) begin
            if (win_v[o] && yumi_i[o]) deq[win[o]] = 1'b1;
        end
        if (reset_i) deq = '0;
    end

    // Credit inputs may push into a full FIFO when the same cycle frees a slot.
    always_comb begin
        for (int i = 0; i < num_in_p; i++) begin
            if (use_credits_p[i]) begin
                enq[i]     = v_i[i] && !reset_i && (!full[i] || deq[i]);
                ovf_set[i] = v_i[i] && !reset_i && full[i] && !deq[i];
            end else begin
                enq[i]     = v_i[i] && !reset_i && !full[i];
                ovf_set[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_in_p; i++) begin
            if (enq[i]) mem_q[i][wr_q[i]] <= data_i[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            credit_q   <= '0;
            overflow_q <= '0;
            bad_dest_q <= '0;
        end else begin
            for (int i = 0; i < num_in_p; i++) begin
                if (enq[i]) wr_q[i] <= inc_addr(wr_q[i]);
                if (deq[i]) rd_q[i] <= inc_addr(rd_q[i]);
                case ({enq[i], deq[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
                    2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
            for (int o = 0; o < num_out_p; o++) begin
                if (win_v[o] && yumi_i[o]) begin
                    ptr_q[o] <= (win[o] == ptr_t'(num_in_p - 1)) ? '0 : win[o] + 1'b1;
                end
            end
            credit_q   <= deq & use_credits_p;
            overflow_q <= overflow_q | ovf_set;
            bad_dest_q <= bad_dest_q | bad_head;
        end
    end

    assign ready_o    = ~full & ~use_credits_p & {num_in_p{~reset_i}};
    assign credit_o   = credit_q & {num_in_p{~reset_i}};
    assign overflow_o = overflow_q & {num_in_p{~reset_i}};
    assign bad_dest_o = bad_dest_q & {num_in_p{~reset_i}};

endmodule

// File: tb/tb_bsg_manycore_xbar_rr.sv
// Randomised and directed bench for bsg_manycore_xbar_rr against a queue-based reference model.
module tb_bsg_manycore_xbar_rr;

    localparam int NI    = 4;
    localparam int NO    = 3;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam logic [NI-1:0] CRED = 4'b1100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset_i;
    logic [NI-1:0]          v_i;
    logic [NI-1:0][W-1:0]   data_i;
    logic [NI-1:0]          ready_o, credit_o, overflow_o, bad_dest_o;
    logic [NO-1:0]          v_o, yumi_i;
    logic [NO-1:0][W-1:0]   data_o;

    bsg_manycore_xbar_rr #(
        .num_in_p(NI), .num_out_p(NO), .width_p(W), .dest_lsb_p(0),
        .fifo_els_p(DEPTH), .use_credits_p(CRED)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .credit_o(credit_o), .v_o(v_o), .data_o(data_o),
        .yumi_i(yumi_i), .overflow_o(overflow_o), .bad_dest_o(bad_dest_o)
    );

    // Reference model: one queue per input, one pointer per output.
    logic [W-1:0]  mq [NI][$];
    int            mptr [NO];
    logic [NI-1:0] m_credit, m_ovf, m_bad;
    logic [NI-1:0] cred_mask;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int m_dest(input logic [W-1:0] p);
        return int'(p) % 4;
    endfunction

    function automatic int m_winner(input int o);
        for (int k = 0; k < NI; k++) begin
            int idx;
            idx = (mptr[o] + k) % NI;
            if (mq[idx].size() > 0 && m_dest(mq[idx][0]) == o) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NO-1:0] avail();
        logic [NO-1:0] a;
        for (int o = 0; o < NO; o++) a[o] = (m_winner(o) >= 0);
        return a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [NO-1:0] ev;
        logic [NI-1:0] er;
        for (int o = 0; o < NO; o++) ev[o] = !reset_i && (m_winner(o) >= 0);
        chk("v_o", 64'(v_o), 64'(ev));
        for (int o = 0; o < NO; o++) begin
            if (ev[o]) chk("data_o", 64'(data_o[o]), 64'(mq[m_winner(o)][0]));
        end
        for (int i = 0; i < NI; i++) er[i] = !reset_i && !cred_mask[i] && (mq[i].size() < DEPTH);
        chk("ready_o", 64'(ready_o), 64'(er));
        chk("credit_o", 64'(credit_o), reset_i ? 64'd0 : 64'(m_credit));
        chk("overflow_o", 64'(overflow_o), reset_i ? 64'd0 : 64'(m_ovf));
        chk("bad_dest_o", 64'(bad_dest_o), reset_i ? 64'd0 : 64'(m_bad));
    endtask

    task automatic model_update();
        int            win [NO];
        logic [NI-1:0] deq, bad, new_credit;
        if (reset_i) begin
            for (int i = 0; i < NI; i++) mq[i].delete();
            for (int o = 0; o < NO; o++) mptr[o] = 0;
            m_credit = '0; m_ovf = '0; m_bad = '0;
            return;
        end
        for (int o = 0; o < NO; o++) win[o] = m_winner(o);
        for (int i = 0; i < NI; i++) begin
            bad[i] = mq[i].size() > 0 && m_dest(mq[i][0]) >= NO;
            deq[i] = bad[i];
        end
        for (int o = 0; o < NO; o++) if (yumi_i[o] && win[o] >= 0) deq[win[o]] = 1'b1;
        new_credit = '0;
        for (int i = 0; i < NI; i++) begin
            bit fullq, acc;
            fullq = (mq[i].size() == DEPTH);
            acc   = 1'b0;
            if (v_i[i]) begin
                if (cred_mask[i]) begin
                    if (!fullq || deq[i]) acc = 1'b1;
                    else m_ovf[i] = 1'b1;
                end else if (!fullq) acc = 1'b1;
            end
            if (deq[i]) begin
                void'(mq[i].pop_front());
                new_credit[i] = cred_mask[i];
            end
            if (acc) mq[i].push_back(data_i[i]);
            if (bad[i]) m_bad[i] = 1'b1;
        end
        for (int o = 0; o < NO; o++) if (yumi_i[o] && win[o] >= 0) mptr[o] = (win[o] + 1) % NI;
        m_credit = new_credit;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        v_i = '0;
        for (int c = 0; c < 40; c++) begin
            yumi_i = avail();
            step();
        end
        yumi_i = '0;
        chk("drained_v_o", 64'(v_o), 64'd0);
    endtask

    initial begin
        int pulses;
        cred_mask = CRED;
        m_credit = '0; m_ovf = '0; m_bad = '0;
        for (int o = 0; o < NO; o++) mptr[o] = 0;
        reset_i = 1'b1; v_i = '0; data_i = '0; yumi_i = '0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) step();
        reset_i = 1'b0;
        #1;
        check_all();
        chk("ready_after_reset", 64'(ready_o), 64'h3);

        // Latency: enqueue at t, visible at t+1, gone after yumi.
        @(negedge clk);
        v_i = 4'b0001; data_i[0] = 16'h00A5;
        step();
        chk("lat_v", 64'(v_o[1]), 64'd1);
        chk("lat_data", 64'(data_o[1]), 64'h00A5);
        v_i = '0; yumi_i = 3'b010;
        step();
        yumi_i = '0;
        chk("lat_v_clear", 64'(v_o[1]), 64'd0);

        // Contention: all inputs target out0.
        for (int i = 0; i < NI; i++) data_i[i] = 16'(i * 256);
        v_i = 4'b1111;
        step();
        for (int g = 0; g < 8; g++) begin
            chk("rr_order", 64'(data_o[0][15:8]), 64'(g % 4));
            yumi_i = avail() & 3'b001;
            for (int i = 0; i < NI; i++) begin
                data_i[i] = 16'(i * 256 + (g + 1) * 4);
                v_i[i]    = (mq[i].size() < DEPTH);
            end
            step();
        end
        v_i = '0; yumi_i = '0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("hold_v", 64'(v_o[0]), 64'd1);
            chk("hold_src", 64'(data_o[0][15:8]), 64'd0);
        end
        drain();

        // Credit mode on input 2, dest 2.
        for (int c = 0; c < 4; c++) begin
            v_i = 4'b0100; data_i[2] = 16'(16'h1202 + c * 16);
            step();
        end
        chk("credit_no_ovf", 64'(overflow_o[2]), 64'd0);
        data_i[2] = 16'h12F2;
        step();
        chk("credit_ovf", 64'(overflow_o[2]), 64'd1);
        v_i = '0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            yumi_i = avail() & 3'b100;
            step();
            if (credit_o[2]) pulses++;
        end
        yumi_i = '0;
        chk("credit_pulses", 64'(pulses), 64'd4);

        // Backpressure on valid/ready input 0, dest 1.
        for (int c = 0; c < 4; c++) begin
            v_i = 4'b0001; data_i[0] = 16'(16'h0B01 + c * 16);
            step();
        end
        chk("bp_full", 64'(ready_o[0]), 64'd0);
        data_i[0] = 16'h0BF1; yumi_i = 3'b010;
        step();
        chk("bp_ready_back", 64'(ready_o[0]), 64'd1);
        drain();

        // Bad destination on input 1.
        v_i = 4'b0010; data_i[1] = 16'h0013;
        step();
        v_i = '0;
        chk("bad_no_v", 64'(v_o), 64'd0);
        chk("bad_not_yet", 64'(bad_dest_o[1]), 64'd0);
        step();
        chk("bad_set", 64'(bad_dest_o[1]), 64'd1);
        v_i = 4'b0010; data_i[1] = 16'h0022;
        step();
        v_i = '0;
        chk("after_bad_v", 64'(v_o[2]), 64'd1);
        chk("after_bad_data", 64'(data_o[2]), 64'h0022);
        yumi_i = 3'b100;
        step();
        yumi_i = '0;
        chk("bad_sticky", 64'(bad_dest_o[1]), 64'd1);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            v_i = 4'($urandom);
            for (int i = 0; i < NI; i++) data_i[i] = 16'($urandom);
            yumi_i = avail() & 3'($urandom);
            step();
        end

        // Reset mid-operation with buffered packets.
        yumi_i = '0;
        for (int c = 0; c < 3; c++) begin
            v_i = 4'b1111;
            for (int i = 0; i < NI; i++) data_i[i] = 16'($urandom_range(0, 255) * 4 + 1);
            step();
        end
        v_i = '0;
        reset_i = 1'b1;
        #1;
        check_all();
        chk("rst_apply_v", 64'(v_o), 64'd0);
        chk("rst_apply_ready", 64'(ready_o), 64'd0);
        step();
        step();
        reset_i = 1'b0;
        #1;
        check_all();
        chk("rst_release_ready", 64'(ready_o), 64'h3);
        for (int c = 0; c < 300; c++) begin
            v_i = 4'($urandom);
            for (int i = 0; i < NI; i++) data_i[i] = 16'($urandom);
            yumi_i = avail() & 3'($urandom);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
